axi_ram_traffic_gen: RTL

- AXI4 master traffic generator that sits directly upstream of axi_ram and drives its slave port in the demo bench.
- It writes NUM_BURSTS INCR bursts of a deterministic pattern, then reads every burst back and checks it.
- It reports busy, done and an error count, so a run can end on done instead of a cycle-count timeout.
- Single outstanding transaction; no interleaving.

---
 rtl/axi_tg_pkg.sv | 34 +++
 rtl/axi_ram_traffic_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_tg_pkg.sv
// Shared types, AXI encodings and helpers for the AXI RAM traffic generator.
// Data pattern and transfer-size helpers are used by both the FSM and its datapath.
package axi_tg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AW,
        W,
        B,
        AR,
        R,
        DONE
    } tg_state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [3:0] CACHE_DEF  = 4'b0011;

    function automatic logic [31:0] tg_pattern(input logic [31:0] addr);
        return addr ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [2:0] tg_size(input int dw);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) == dw / 8) begin
                s = 3'(i);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/axi_ram_traffic_gen.sv
// AXI4 master that writes NUM_BURSTS INCR bursts of a fixed pattern,
// reads them back, and counts every failing response or beat.
module axi_ram_traffic_gen
    import axi_tg_pkg::*;
#(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 16,
    parameter int                  ID_WIDTH   = 8,
    parameter logic [ID_WIDTH-1:0] TXN_ID     = '0,
    parameter int                  BURST_LEN  = 8,
    parameter int                  NUM_BURSTS = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             err_count,

    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awlock,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,

    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,

    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,

    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arlock,
    output logic [3:0]              m_axi_arcache,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,

    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int              NBYTES     = DATA_WIDTH / 8;
    localparam int              NLANES     = DATA_WIDTH / 32;
    localparam logic [2:0]      SIZE       = tg_size(DATA_WIDTH);
    localparam logic [7:0]      AXLEN      = 8'(BURST_LEN - 1);
    localparam logic [8:0]      LAST_BEAT  = 9'(BURST_LEN - 1);
    localparam logic [15:0]     LAST_BURST = 16'(NUM_BURSTS - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BURST_LEN * NBYTES);

    tg_state_e              state_q, state_d;
    logic [8:0]             beat_q, beat_d;
    logic [15:0]            burst_q, burst_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [15:0]            err_q, err_d;

    logic [ADDR_WIDTH-1:0]  beat_addr;
    logic [31:0]            beat_pat;
    logic [DATA_WIDTH-1:0]  exp_data;
    logic                   last_beat;
    logic                   last_burst;
    logic                   b_bad;
    logic                   rd_bad;
    logic                   err_inc;

    assign beat_addr  = addr_q + (ADDR_WIDTH'(beat_q) << SIZE);
    assign beat_pat   = tg_pattern(32'(beat_addr));
    assign exp_data   = {NLANES{beat_pat}};
    assign last_beat  = (beat_q == LAST_BEAT);
    assign last_burst = (burst_q == LAST_BURST);

    assign b_bad = (m_axi_bresp != RESP_OKAY) || (m_axi_bid != TXN_ID);

    // one error per bad beat, however many fields disagree
    assign rd_bad = (m_axi_rdata != exp_data)
                 || (m_axi_rresp != RESP_OKAY)
                 || (m_axi_rid != TXN_ID)
                 || (m_axi_rlast != last_beat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            burst_q <= '0;
            addr_q  <= BASE_ADDR;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            burst_q <= burst_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        burst_d = burst_q;
        addr_d  = addr_q;
        err_d   = err_q;
        err_inc = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = AW;
                    beat_d  = '0;
                    burst_d = '0;
                    addr_d  = BASE_ADDR;
                    err_d   = '0;
                end
            end
            AW: begin
                if (m_axi_awready) begin
                    state_d = W;
                end
            end
            W: begin
                if (m_axi_wready) begin
                    if (last_beat) begin
                        state_d = B;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 9'd1;
                    end
                end
            end
            B: begin
                if (m_axi_bvalid) begin
                    err_inc = b_bad;
                    if (last_burst) begin
                        state_d = AR;
                        burst_d = '0;
                        addr_d  = BASE_ADDR;
                    end else begin
                        state_d = AW;
                        burst_d = burst_q + 16'd1;
                        addr_d  = addr_q + STEP;
                    end
                end
            end
            AR: begin
                if (m_axi_arready) begin
                    state_d = R;
                end
            end
            R: begin
                if (m_axi_rvalid) begin
                    err_inc = rd_bad;
                    if (m_axi_rlast) begin
                        beat_d = '0;
                        if (last_burst) begin
                            state_d = DONE;
                        end else begin
                            state_d = AR;
                            burst_d = burst_q + 16'd1;
                            addr_d  = addr_q + STEP;
                        end
                    end else if (beat_q != 9'h1FF) begin
                        // stays pinned so an overlong burst never re-matches LAST_BEAT
                        beat_d = beat_q + 9'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (err_inc && err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
        end
    end

    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = (state_q == DONE);
    assign err_count = err_q;

    assign m_axi_awid    = TXN_ID;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = AXLEN;
    assign m_axi_awsize  = SIZE;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = CACHE_DEF;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = (state_q == AW);

    assign m_axi_wdata  = exp_data;
    assign m_axi_wstrb  = '1;
    assign m_axi_wlast  = last_beat;
    assign m_axi_wvalid = (state_q == W);

    assign m_axi_bready = (state_q == B);

    assign m_axi_arid    = TXN_ID;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = AXLEN;
    assign m_axi_arsize  = SIZE;
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = CACHE_DEF;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = (state_q == AR);

    assign m_axi_rready = (state_q == R);

endmodule
